// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcodes, control codes and state encoding for the multi-cycle MIPS controller
package multicycle_control_pkg;
  localparam logic [5:0] MIPS_RTYPE = 6'h00;
  localparam logic [5:0] MIPS_J     = 6'h02;
  localparam logic [5:0] MIPS_JAL   = 6'h03;
  localparam logic [5:0] MIPS_BEQ   = 6'h04;
  localparam logic [5:0] MIPS_BNE   = 6'h05;
  localparam logic [5:0] MIPS_ADDI  = 6'h08;
  localparam logic [5:0] MIPS_ANDI  = 6'h0C;
  localparam logic [5:0] MIPS_ORI   = 6'h0D;
  localparam logic [5:0] MIPS_XORI  = 6'h0E;
  localparam logic [5:0] MIPS_LUI   = 6'h0F;
  localparam logic [5:0] MIPS_LW    = 6'h23;
  localparam logic [5:0] MIPS_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [1:0] ALUOP_LW_SW_ADDI    = 2'b00;
  localparam logic [1:0] ALUOP_BEQ_BNE       = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE         = 2'b10;
  localparam logic [1:0] ALUOP_ANDI_ORI_XORI = 2'b11;
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3,
    MEM_WB = 4'd4, MEM_WRITE = 4'd5, EXEC_R = 4'd6, ALU_WB = 4'd7,
    EXEC_I = 4'd8, IMM_WB = 4'd9, BRANCH = 4'd10, JUMP = 4'd11,
    JAL_WB = 4'd12, JR = 4'd13, LUI_WB = 4'd14, FAULT = 4'd15
  } state_t;
  function automatic logic isLogicImm(input logic [5:0] op);
    return op inside {MIPS_ANDI, MIPS_ORI, MIPS_XORI};
  endfunction
endpackage

// File: rtl/multicycle_control_mem_timeout_ctr.sv
// mem_timeout_ctr: counts consecutive memory wait cycles and flags the last allowed one
module mem_timeout_ctr #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);
  logic [TO_W-1:0] count;
  logic counting;
  assign counting = en && !clr;
  // count holds the waits already spent, so this cycle is wait number count+1
  assign expired = counting && (count == TO_W'(MEM_TIMEOUT - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= counting ? count + 1'b1 : '0;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS main controller with memory handshake timeout
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       BranchNe,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       ExtOp,
  output logic       JalEn,
  output logic       LuiEn,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       fault,
  output logic [3:0] state_o
);
  state_t state, nextState;
  logic toExpired;
  mem_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) timeoutCtr (
    .clk(clk),
    .rst_n(rst_n),
    .en(state inside {FETCH, MEM_READ, MEM_WRITE}),
    .clr(mem_ready),
    .expired(toExpired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= nextState;
  assign state_o = state;
  always_comb begin
    nextState = state;
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    MemtoReg = 1'b0;
    RegDst = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = SRCB_REGB;
    ALUOp = ALUOP_LW_SW_ADDI;
    PCSource = PCSRC_ALU;
    ExtOp = 1'b1;
    JalEn = 1'b0;
    LuiEn = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    fault = 1'b0;
    unique case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        nextState = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        case (opcode)
          MIPS_RTYPE: nextState = (funct == FUNCT_JR) ? JR : EXEC_R;
          MIPS_LW, MIPS_SW: nextState = MEM_ADDR;
          MIPS_BEQ, MIPS_BNE: nextState = BRANCH;
          MIPS_ADDI, MIPS_ANDI, MIPS_ORI, MIPS_XORI: nextState = EXEC_I;
          MIPS_J: nextState = JUMP;
          MIPS_JAL: nextState = JAL_WB;
          MIPS_LUI: nextState = LUI_WB;
          default: begin
            nextState = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp = ALUOP_RTYPE;
        nextState = ALU_WB;
      end
      ALU_WB: begin
        RegDst = 1'b1;
        RegWrite = 1'b1;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ExtOp = !isLogicImm(opcode);
        ALUOp = isLogicImm(opcode) ? ALUOP_ANDI_ORI_XORI : ALUOP_LW_SW_ADDI;
        nextState = IMM_WB;
      end
      IMM_WB: begin
        RegWrite = 1'b1;
        ExtOp = !isLogicImm(opcode);
        ALUOp = isLogicImm(opcode) ? ALUOP_ANDI_ORI_XORI : ALUOP_LW_SW_ADDI;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        nextState = (opcode == MIPS_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        nextState = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        instr_done = mem_ready;
        nextState = mem_ready ? FETCH : MEM_WRITE;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = ALUOP_BEQ_BNE;
        PCWriteCond = 1'b1;
        PCSource = PCSRC_ALUOUT;
        BranchNe = (opcode == MIPS_BNE);
        instr_done = 1'b1;
        nextState = FETCH;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSource = PCSRC_JUMP;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      JAL_WB: begin
        PCWrite = 1'b1;
        PCSource = PCSRC_JUMP;
        RegWrite = 1'b1;
        JalEn = 1'b1;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      JR: begin
        PCWrite = 1'b1;
        PCSource = PCSRC_REGA;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      LUI_WB: begin
        RegWrite = 1'b1;
        LuiEn = 1'b1;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      FAULT: fault = 1'b1;
    endcase
    if (toExpired) nextState = FAULT;
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction stream checked cycle by cycle against a per-instruction step model
module tb_multicycle_control;
  localparam int TO = 4;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, FN_JR = 6'h08;
  localparam logic [1:0] A_ADD = 2'd0, A_BR = 2'd1, A_R = 2'd2, A_LOG = 2'd3;
  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srcA;
    logic [1:0] srcB, aluop, pcsrc;
    logic ext, jal, lui, done, ill, flt;
  } vec_t;
  logic clk = 0, rst_n = 0, mem_ready = 0;
  logic [5:0] opcode = 0, funct = 0;
  logic PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic ExtOp, JalEn, LuiEn, instr_done, illegal_op, fault;
  logic [3:0] state_o;
  vec_t got, expV;
  vec_t bq[$];
  bit br[$];
  bit expOn = 0, fresh = 0;
  int checks = 0, errors = 0;
  int stepIdx, firstDone, rwCnt, illCnt, mwCnt, doneCnt;
  multicycle_control #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .ExtOp(ExtOp), .JalEn(JalEn), .LuiEn(LuiEn),
    .instr_done(instr_done), .illegal_op(illegal_op), .fault(fault), .state_o(state_o)
  );
  always #5 clk = ~clk;
  assign got = {state_o, PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp, JalEn, LuiEn,
                instr_done, illegal_op, fault};
  always @(negedge clk) if (expOn) begin
    checks++;
    if (got !== expV) begin
      errors++;
      $display("FAIL step%0d state%0d: got %h want %h", stepIdx, expV.st, got, expV);
    end
    if (instr_done && firstDone < 0) firstDone = stepIdx;
    doneCnt += int'(instr_done);
    rwCnt += int'(RegWrite);
    illCnt += int'(illegal_op);
    mwCnt += int'(MemWrite);
    stepIdx++;
  end
  task automatic chk(input string name, input int g, input int w);
    checks++;
    if (g != w) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, g, w);
    end
  endtask
  function automatic bit rnd();
    return 1'($urandom);
  endfunction
  function automatic vec_t dflt(input logic [3:0] st);
    vec_t v = '0;
    v.st = st;
    v.ext = 1'b1;
    v.aluop = A_ADD;
    return v;
  endfunction
  function automatic void put(input vec_t v, input bit r);
    bq.push_back(v);
    br.push_back(r);
  endfunction
  // n wait cycles then a ready cycle; at TO waits the controller must give up and park in FAULT
  function automatic bit memPhase(input vec_t w, input vec_t r, input int n);
    vec_t f = dflt(4'd15);
    f.flt = 1'b1;
    for (int i = 0; i < n && i < TO; i++) put(w, 1'b0);
    if (n >= TO) begin
      for (int i = 0; i < 3; i++) put(f, rnd());
      return 1'b1;
    end
    put(r, 1'b1);
    return 1'b0;
  endfunction
  function automatic bit build(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw);
    vec_t w, r;
    bit lgc;
    bq.delete();
    br.delete();
    w = dflt(4'd0); w.mrd = 1; w.srcB = 2'd1;
    r = w; r.irw = 1; r.pcw = 1;
    if (memPhase(w, r, fw)) return 1'b1;
    w = dflt(4'd1); w.srcB = 2'd3;
    w.ill = !(op inside {OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW});
    put(w, rnd());
    lgc = op inside {OP_ANDI, OP_ORI, OP_XORI};
    case (op)
      OP_R: begin
        if (fn == FN_JR) begin
          w = dflt(4'd13); w.pcw = 1; w.pcsrc = 2'd3; w.done = 1; put(w, rnd());
        end else begin
          w = dflt(4'd6); w.srcA = 1; w.srcB = 2'd0; w.aluop = A_R; put(w, rnd());
          w = dflt(4'd7); w.rdst = 1; w.rw = 1; w.done = 1; put(w, rnd());
        end
      end
      OP_LW, OP_SW: begin
        w = dflt(4'd2); w.srcA = 1; w.srcB = 2'd2; put(w, rnd());
        if (op == OP_LW) begin
          w = dflt(4'd3); w.mrd = 1; w.iord = 1;
          if (memPhase(w, w, mw)) return 1'b1;
          w = dflt(4'd4); w.rw = 1; w.m2r = 1; w.done = 1; put(w, rnd());
        end else begin
          w = dflt(4'd5); w.mwr = 1; w.iord = 1;
          r = w; r.done = 1;
          if (memPhase(w, r, mw)) return 1'b1;
        end
      end
      OP_BEQ, OP_BNE: begin
        w = dflt(4'd10); w.srcA = 1; w.srcB = 2'd0; w.aluop = A_BR; w.pcwc = 1; w.pcsrc = 2'd1;
        w.bne = (op == OP_BNE); w.done = 1; put(w, rnd());
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        w = dflt(4'd8); w.srcA = 1; w.srcB = 2'd2;
        if (lgc) begin w.ext = 0; w.aluop = A_LOG; end
        put(w, rnd());
        r = dflt(4'd9); r.rw = 1; r.ext = w.ext; r.aluop = w.aluop; r.done = 1; put(r, rnd());
      end
      OP_J: begin w = dflt(4'd11); w.pcw = 1; w.pcsrc = 2'd2; w.done = 1; put(w, rnd()); end
      OP_JAL: begin w = dflt(4'd12); w.pcw = 1; w.pcsrc = 2'd2; w.rw = 1; w.jal = 1; w.done = 1; put(w, rnd()); end
      OP_LUI: begin w = dflt(4'd14); w.rw = 1; w.lui = 1; w.done = 1; put(w, rnd()); end
      default: ;
    endcase
    return 1'b0;
  endfunction
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw, output bit flt);
    flt = build(op, fn, fw, mw);
    firstDone = -1; rwCnt = 0; illCnt = 0; mwCnt = 0; doneCnt = 0; stepIdx = 0;
    foreach (bq[i]) begin
      if (!(i == 0 && fresh)) begin @(posedge clk); #1; end
      if (i == 0) begin opcode = op; funct = fn; fresh = 0; end
      mem_ready = br[i];
      expV = bq[i];
      expOn = 1;
    end
    @(negedge clk); #1;
    expOn = 0;
  endtask
  task automatic faultReset();
    chk("fault_sticky", int'(fault), 1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_state", int'(state_o), 0);
    chk("async_rst_fault", int'(fault), 0);
    @(posedge clk); #1;
    mem_ready = 0;
    rst_n = 1;
    fresh = 1;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    bit flt;
    logic [5:0] ops[16] = '{OP_R, OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
                            OP_ORI, OP_XORI, OP_J, OP_JAL, OP_LUI, 6'h3F, 6'h01, 6'h10};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(state_o), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_memread", int'(MemRead), 1);
    chk("rst_done", int'(instr_done), 0);
    rst_n = 1;
    fresh = 1;
    run(OP_R, 6'h20, 0, 0, flt);
    chk("add_cycles", firstDone + 1, 4);
    chk("add_done_pulses", doneCnt, 1);
    chk("add_regwrite", rwCnt, 1);
    run(OP_LW, 6'h00, 0, 3, flt);
    chk("lw_wait_cycles", firstDone + 1, 8);
    run(OP_BNE, 6'h00, 0, 0, flt);
    chk("bne_cycles", firstDone + 1, 3);
    run(OP_ORI, 6'h15, 0, 0, flt);
    chk("ori_cycles", firstDone + 1, 4);
    run(OP_R, FN_JR, 0, 0, flt);
    chk("jr_cycles", firstDone + 1, 3);
    chk("jr_no_regwrite", rwCnt, 0);
    run(6'h3F, 6'h00, 0, 0, flt);
    chk("illegal_pulses", illCnt, 1);
    chk("illegal_no_done", doneCnt, 0);
    chk("illegal_no_write", rwCnt + mwCnt, 0);
    run(OP_SW, 6'h00, 1, 2, flt);
    chk("sw_wait_cycles", firstDone + 1, 7);
    run(OP_R, 6'h20, TO, 0, flt);
    chk("fetch_timeout_flag", int'(flt), 1);
    faultReset();
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op, fn;
      int fw, mw;
      op = ops[$urandom_range(0, 15)];
      fn = ($urandom_range(0, 3) == 0) ? FN_JR : 6'($urandom);
      fw = ($urandom_range(0, 39) == 0) ? TO : $urandom_range(0, TO - 1);
      mw = ($urandom_range(0, 19) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, TO - 1);
      run(op, fn, fw, mw, flt);
      if (flt) faultReset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
